// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the single-cycle RV32I core: opcode and funct
// constants, ALU operation and immediate-format enumerations, write-back
// source selection, the canonical NOP word and the immediate generator.
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3 (word only)
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SW = 3'b010;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    // Assemble the sign-extended immediate for the given instruction format.
    function automatic logic [31:0] gen_imm(input logic [31:0] insn, input imm_type_e imm_type);
        logic [31:0] res;
        case (imm_type)
            IMM_I:   res = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   res = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   res = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   res = {insn[31:12], 12'h000};
            IMM_J:   res = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// -----------------------------------------------------------------------------
// rv32i_alu
// Combinational RV32I integer ALU. 32-bit wrap-around arithmetic, shift
// amount from the low 5 bits of operand B, arithmetic right shift sign-fills.
// Ports:
//   i_a   in   operand A [31:0]
//   i_b   in   operand B [31:0]
//   i_op  in   operation (alu_op_e)
//   o_y   out  result [31:0]
// -----------------------------------------------------------------------------
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_e     i_op,
    output logic [31:0] o_y
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // Operation select.
    always_comb begin
        o_y = 32'h0000_0000;
        case (i_op)
            ALU_ADD:    o_y = i_a + i_b;
            ALU_SUB:    o_y = i_a - i_b;
            ALU_SLL:    o_y = i_a << w_shamt;
            ALU_SLT:    o_y = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   o_y = (i_a < i_b) ? 32'd1 : 32'd0;
            ALU_XOR:    o_y = i_a ^ i_b;
            ALU_SRL:    o_y = i_a >> w_shamt;
            ALU_SRA:    o_y = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:     o_y = i_a | i_b;
            ALU_AND:    o_y = i_a & i_b;
            ALU_PASS_B: o_y = i_b;
            default:    o_y = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rv32i_mem.sv
// -----------------------------------------------------------------------------
// rv32i_mem
// Generic word-addressed memory used for both instruction and data storage.
// Combinational read, write on the rising clock edge. Contents are never
// cleared so simulation preloads survive reset. Byte-address bits above the
// index field and the two byte-offset bits are ignored (address wraps).
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_addr   in   byte address [31:0]
//   i_wdata  in   write data [31:0]
//   o_rdata  out  read data [31:0] (combinational)
// -----------------------------------------------------------------------------
module rv32i_mem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [0:MEM_WORDS-1];
    logic [AW-1:0] w_idx;
    logic          w_unused_addr_bits;

    assign w_idx              = i_addr[AW+1:2];
    assign w_unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};
    assign o_rdata            = mem[w_idx];

    // Synchronous word write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/rv32i_regfile.sv
// -----------------------------------------------------------------------------
// rv32i_regfile
// 32 x 32-bit integer register file: two combinational read ports and one
// write port on the rising edge. x0 reads as zero and ignores writes. A read
// of the register being written in the same cycle returns the old value.
// Not reset, so preloaded contents survive.
// Ports:
//   clk         in   clock
//   i_rs1_addr  in   read port 1 address
//   i_rs2_addr  in   read port 2 address
//   o_rs1_data  out  read port 1 data
//   o_rs2_data  out  read port 2 data
//   i_we        in   write enable
//   i_rd_addr   in   write address
//   i_rd_data   in   write data
// -----------------------------------------------------------------------------
module rv32i_regfile (
    input  logic        clk,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data
);

    logic [31:0] regFile [0:31];

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'h0000_0000 : regFile[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'h0000_0000 : regFile[i_rs2_addr];

    // Register write-back; x0 is hard-wired to zero.
    always_ff @(posedge clk) begin
        if (i_we && (i_rd_addr != 5'd0)) begin
            regFile[i_rd_addr] <= i_rd_data;
        end
    end

endmodule

// File: rtl/rv32i_core.sv
// -----------------------------------------------------------------------------
// rv32i_core
// Single-cycle RV32I integer core with internal instruction and data
// memories. Every rising edge retires one instruction. Reset only touches
// the PC (forced asynchronously to RESET_PC) and substitutes a NOP for the
// fetched instruction while asserted; register file and memories keep their
// contents.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
// -----------------------------------------------------------------------------
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);

    logic [31:0] pc;
    logic [31:0] pc_in;
    logic [31:0] instruction_mux_out;
    logic [31:0] mux_a_out;
    logic [31:0] mux_b_out;
    logic [31:0] alu_out;

    logic [31:0] w_fetch;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm;
    logic [31:0] w_load_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_wb_data;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;

    alu_op_e     w_alu_op;
    imm_type_e   w_imm_type;
    wb_sel_e     w_wb_sel;
    logic        w_sel_a_pc;
    logic        w_sel_b_rs2;
    logic        w_reg_we;
    logic        w_mem_we;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_branch_taken;

    // ---------------------------------------------------------------- fetch
    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) insn_memory (
        .clk     (clk),
        .i_we    (1'b0),
        .i_addr  (pc),
        .i_wdata (32'h0000_0000),
        .o_rdata (w_fetch)
    );

    assign instruction_mux_out = reset ? w_fetch : NOP_INSN;

    assign w_opcode = instruction_mux_out[6:0];
    assign w_rd     = instruction_mux_out[11:7];
    assign w_funct3 = instruction_mux_out[14:12];
    assign w_rs1    = instruction_mux_out[19:15];
    assign w_rs2    = instruction_mux_out[24:20];
    assign w_funct7 = instruction_mux_out[31:25];

    // --------------------------------------------------------------- decode
    // Control decode; anything unrecognised falls through as a NOP.
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_imm_type  = IMM_NONE;
        w_wb_sel    = WB_ALU;
        w_sel_a_pc  = 1'b0;
        w_sel_b_rs2 = 1'b0;
        w_reg_we    = 1'b0;
        w_mem_we    = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_imm_type = IMM_U;
                w_alu_op   = ALU_PASS_B;
                w_reg_we   = 1'b1;
            end
            OP_AUIPC: begin
                w_imm_type = IMM_U;
                w_sel_a_pc = 1'b1;
                w_reg_we   = 1'b1;
            end
            OP_JAL: begin
                w_imm_type = IMM_J;
                w_wb_sel   = WB_PC4;
                w_reg_we   = 1'b1;
                w_is_jal   = 1'b1;
            end
            OP_JALR: begin
                w_imm_type = IMM_I;
                w_wb_sel   = WB_PC4;
                w_reg_we   = 1'b1;
                w_is_jalr  = 1'b1;
            end
            OP_BRANCH: begin
                w_imm_type  = IMM_B;
                w_sel_b_rs2 = 1'b1;
                w_is_branch = 1'b1;
            end
            OP_LOAD: begin
                if (w_funct3 == F3_LW) begin
                    w_imm_type = IMM_I;
                    w_wb_sel   = WB_MEM;
                    w_reg_we   = 1'b1;
                end else begin
                    w_reg_we   = 1'b0;
                end
            end
            OP_STORE: begin
                if (w_funct3 == F3_SW) begin
                    w_imm_type = IMM_S;
                    w_mem_we   = 1'b1;
                end else begin
                    w_mem_we   = 1'b0;
                end
            end
            OP_IMM: begin
                w_imm_type = IMM_I;
                w_reg_we   = 1'b1;
                case (w_funct3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR:   w_alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            OP_REG: begin
                w_sel_b_rs2 = 1'b1;
                w_reg_we    = 1'b1;
                case (w_funct3)
                    F3_ADD:  w_alu_op = (w_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR:   w_alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            default: begin
                w_reg_we = 1'b0;
            end
        endcase
    end

    assign w_imm = gen_imm(instruction_mux_out, w_imm_type);

    // -------------------------------------------------------------- execute
    rv32i_regfile register_file (
        .clk        (clk),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (w_reg_we),
        .i_rd_addr  (w_rd),
        .i_rd_data  (w_wb_data)
    );

    assign mux_a_out = w_sel_a_pc  ? pc         : w_rs1_data;
    assign mux_b_out = w_sel_b_rs2 ? w_rs2_data : w_imm;

    rv32i_alu alu (
        .i_a  (mux_a_out),
        .i_b  (mux_b_out),
        .i_op (w_alu_op),
        .o_y  (alu_out)
    );

    // Branch condition evaluated directly on the register operands.
    always_comb begin
        w_branch_taken = 1'b0;
        if (w_is_branch) begin
            case (w_funct3)
                F3_BEQ:  w_branch_taken = (w_rs1_data == w_rs2_data);
                F3_BNE:  w_branch_taken = (w_rs1_data != w_rs2_data);
                F3_BLT:  w_branch_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
                F3_BGE:  w_branch_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
                F3_BLTU: w_branch_taken = (w_rs1_data <  w_rs2_data);
                F3_BGEU: w_branch_taken = (w_rs1_data >= w_rs2_data);
                default: w_branch_taken = 1'b0;
            endcase
        end else begin
            w_branch_taken = 1'b0;
        end
    end

    // --------------------------------------------------------------- memory
    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) data_memory (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (alu_out),
        .i_wdata (w_rs2_data),
        .o_rdata (w_load_data)
    );

    // ----------------------------------------------------------- write-back
    assign w_pc_plus4 = pc + 32'd4;

    // Write-back source select.
    always_comb begin
        w_wb_data = alu_out;
        case (w_wb_sel)
            WB_ALU:  w_wb_data = alu_out;
            WB_MEM:  w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = w_pc_plus4;
            default: w_wb_data = alu_out;
        endcase
    end

    // -------------------------------------------------------------- next PC
    // JALR target clears bit 0; JAL and taken branches are PC-relative.
    always_comb begin
        pc_in = w_pc_plus4;
        if (w_is_jalr) begin
            pc_in = (w_rs1_data + w_imm) & 32'hFFFF_FFFE;
        end else if (w_is_jal || w_branch_taken) begin
            pc_in = pc + w_imm;
        end else begin
            pc_in = w_pc_plus4;
        end
    end

    // Program counter; reset forces RESET_PC without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_in;
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// -----------------------------------------------------------------------------
// tb_rv32i_core
// Directed programs are preloaded into the core's memories; the expected
// architectural state after each run is queued when the program is loaded
// and compared against the core once the run has finished.
// -----------------------------------------------------------------------------
module tb_rv32i_core;

    logic clk;
    logic reset;

    int checks;
    int failures;

    typedef struct {
        int          kind;   // 0 reg, 1 pc, 2 data mem word, 3 fetched insn
        int          idx;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    rv32i_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // ---------------- scoreboard
    task automatic push(input int kind, input int idx, input logic [31:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       obs = dut.register_file.regFile[e.idx];
                1:       obs = dut.pc;
                2:       obs = dut.data_memory.mem[e.idx];
                default: obs = dut.instruction_mux_out;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Assert reset and preload: regFile[k]=k, insn memory cleared to zero.
    task automatic start_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) dut.insn_memory.mem[i] = 32'h0000_0000;
        for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
    endtask

    task automatic release_and_run(input int n);
        #5;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;

        // ---- reset state
        #2;
        push(1, 0, 32'h0000_0000, "reset_pc");
        push(3, 0, 32'h0000_0013, "reset_nop");
        check_all();

        // ---- test 1: ADDI/ADDI/SLTU, unsigned not-less
        start_reset();
        dut.insn_memory.mem[0] = enc_i(12'd50, 5'd1, 3'b000, 5'd1, 7'h13);
        dut.insn_memory.mem[1] = enc_i(12'd20, 5'd2, 3'b000, 5'd2, 7'h13);
        dut.insn_memory.mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3);
        push(0, 1, 32'd51, "t1_x1");
        push(0, 2, 32'd22, "t1_x2");
        push(0, 3, 32'd0,  "t1_x3");
        push(1, 0, 32'd12, "t1_pc");
        release_and_run(3);

        // ---- mid-run reset: pc drops without a clock edge
        reset = 1'b0;
        #1;
        push(1, 0, 32'h0000_0000, "midrst_pc");
        push(3, 0, 32'h0000_0013, "midrst_nop");
        check_all();
        #3;
        reset = 1'b1;
        push(0, 1, 32'd101, "midrst_x1_reexec");
        push(0, 2, 32'd22,  "midrst_x2_kept");
        push(0, 3, 32'd0,   "midrst_x3_kept");
        push(1, 0, 32'd4,   "midrst_pc_after");
        run(1);

        // ---- test 2: SLTU true
        start_reset();
        dut.insn_memory.mem[0] = enc_i(12'd20, 5'd1, 3'b000, 5'd1, 7'h13);
        dut.insn_memory.mem[1] = enc_i(12'd50, 5'd2, 3'b000, 5'd2, 7'h13);
        dut.insn_memory.mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3);
        push(0, 1, 32'd21, "t2_x1");
        push(0, 2, 32'd52, "t2_x2");
        push(0, 3, 32'd1,  "t2_x3");
        release_and_run(3);

        // ---- test 3: signed vs unsigned compare
        start_reset();
        dut.register_file.regFile[1] = 32'hFFFF_FFFF;
        dut.register_file.regFile[2] = 32'h0000_0001;
        dut.insn_memory.mem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
        dut.insn_memory.mem[1] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4);
        push(0, 3, 32'd1, "t3_slt");
        push(0, 4, 32'd0, "t3_sltu");
        release_and_run(2);

        // ---- test 4: x0 write ignored, SW then LW
        start_reset();
        dut.register_file.regFile[2] = 32'hDEAD_BEEF;
        dut.data_memory.mem[0] = 32'h0000_0000;
        dut.insn_memory.mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13);
        dut.insn_memory.mem[1] = enc_s(12'd0, 5'd2, 5'd0);
        dut.insn_memory.mem[2] = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'h03);
        push(0, 0, 32'd0,         "t4_x0");
        push(2, 0, 32'hDEAD_BEEF, "t4_dmem0");
        push(0, 5, 32'hDEAD_BEEF, "t4_lw_x5");
        release_and_run(3);

        // ---- test 5: BEQ taken, JAL link
        start_reset();
        dut.insn_memory.mem[0] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
        dut.insn_memory.mem[2] = enc_j(21'd16, 5'd1);
        push(1, 0, 32'd8, "t5_beq_pc");
        release_and_run(1);
        push(0, 1, 32'd12, "t5_jal_link");
        push(1, 0, 32'd24, "t5_jal_pc");
        run(1);

        // ---- test 6: shifts, SUB, LUI, AUIPC, SLTIU, JALR, BNE, wrap
        start_reset();
        dut.register_file.regFile[1]  = 32'h8000_0000;
        dut.register_file.regFile[2]  = 32'h0000_0004;
        dut.register_file.regFile[13] = 32'h0000_1000;
        dut.data_memory.mem[1] = 32'h0000_0000;
        dut.insn_memory.mem[0]  = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3);     // SRA
        dut.insn_memory.mem[1]  = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd4);     // SRL
        dut.insn_memory.mem[2]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd5);     // SUB
        dut.insn_memory.mem[3]  = enc_u(20'h12345, 5'd6, 7'h37);              // LUI
        dut.insn_memory.mem[4]  = enc_u(20'h00001, 5'd7, 7'h17);              // AUIPC
        dut.insn_memory.mem[5]  = enc_i(12'hFFF, 5'd2, 3'b011, 5'd8, 7'h13);  // SLTIU -1
        dut.insn_memory.mem[6]  = enc_i(12'd41, 5'd0, 3'b000, 5'd9, 7'h67);   // JALR -> 40
        dut.insn_memory.mem[10] = enc_b(13'd8, 5'd2, 5'd2, 3'b001);           // BNE not taken
        dut.insn_memory.mem[11] = enc_i(12'h408, 5'd1, 3'b101, 5'd10, 7'h13); // SRAI 8
        dut.insn_memory.mem[12] = enc_i(12'd3, 5'd2, 3'b001, 5'd11, 7'h13);   // SLLI 3
        dut.insn_memory.mem[13] = enc_i(12'hFFF, 5'd2, 3'b100, 5'd12, 7'h13); // XORI -1
        dut.insn_memory.mem[14] = enc_s(12'd4, 5'd2, 5'd13);                  // SW wraps to word 1
        dut.insn_memory.mem[15] = enc_i(12'd4, 5'd0, 3'b010, 5'd14, 7'h03);   // LW word 1
        push(0, 3,  32'hF800_0000, "t6_sra");
        push(0, 4,  32'h0800_0000, "t6_srl");
        push(0, 5,  32'h8000_0004, "t6_sub");
        push(0, 6,  32'h1234_5000, "t6_lui");
        push(0, 7,  32'h0000_1010, "t6_auipc");
        push(0, 8,  32'd1,         "t6_sltiu");
        push(0, 9,  32'd28,        "t6_jalr_link");
        push(0, 10, 32'hFF80_0000, "t6_srai");
        push(0, 11, 32'd32,        "t6_slli");
        push(0, 12, 32'hFFFF_FFFB, "t6_xori");
        push(2, 1,  32'h0000_0004, "t6_sw_wrap");
        push(0, 14, 32'h0000_0004, "t6_lw_wrap");
        push(1, 0,  32'd64,        "t6_pc");
        release_and_run(13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
